qspi_flash_sequencer: RTL and testbench

Sequences complete SPI-NOR flash operations (read, page program, sector erase) on top of `qspi_mem_controller`. It accepts one high-level request, issues the required chain of single transactions (WREN, WEL check, command, status polling), and returns one result with an error code. It is the only master of the controller's `trigger`/`data_in` interface.

---
 rtl/qspi_flash_pkg.sv | 33 +++
 rtl/qspi_flash_sequencer_txn.sv | 48 ++++
 rtl/qspi_flash_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_qspi_flash_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_flash_pkg.sv
// Shared constants and state/result encodings for the SPI-NOR flash sequencer.
package qspi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_RSVD    = 2'd3
  } op_code_t;

  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_ARGS    = 3'd1,
    ERR_WEL     = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_CTRL    = 3'd4
  } err_code_t;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_CHECK, ST_WREN, ST_WEL_RD, ST_CMD, ST_POLL, ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_WAIT_HI, TX_WAIT_LO
  } txn_state_t;

endpackage

// File: rtl/qspi_flash_sequencer_txn.sv
// Single-transaction handshake with the memory controller: trigger pulse,
// busy rise, busy fall, then readout/error capture reported as txn_done.
module qspi_txn_issuer
  import qspi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mc_busy,
  input  logic        mc_error,
  input  logic [63:0] mc_readout,
  output logic        mc_trigger,
  output logic        txn_done,
  output logic        txn_error,
  output logic [63:0] txn_readout
);

  txn_state_t tstate;

  always_ff @(posedge clk) begin
    if (reset) begin
      tstate      <= TX_IDLE;
      mc_trigger  <= 1'b0;
      txn_done    <= 1'b0;
      txn_error   <= 1'b0;
      txn_readout <= '0;
    end else begin
      mc_trigger <= 1'b0;
      txn_done   <= 1'b0;
      case (tstate)
        TX_IDLE: if (start) begin
          mc_trigger <= 1'b1;
          tstate     <= TX_WAIT_HI;
        end
        TX_WAIT_HI: if (mc_busy) tstate <= TX_WAIT_LO;
        // readout and error are only meaningful in the cycle busy drops
        TX_WAIT_LO: if (!mc_busy) begin
          txn_readout <= mc_readout;
          txn_error   <= mc_error;
          txn_done    <= 1'b1;
          tstate      <= TX_IDLE;
        end
        default: tstate <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/qspi_flash_sequencer.sv
// Turns one READ / PROGRAM / ERASE request into the chain of flash
// transactions (WREN, WEL check, command, status polling) and one result.
module qspi_flash_sequencer
  import qspi_flash_pkg::*;
#(
  parameter int MAXCMD   = 256,
  parameter int POLL_MAX = 1000000,
  localparam int DIN_W   = (3 + MAXCMD) * 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_code,
  input  logic [23:0]         op_addr,
  input  logic [8:0]          op_len,
  input  logic [MAXCMD*8-1:0] op_wdata,
  output logic                done,
  output logic [2:0]          err_code,
  output logic [63:0]         rdata,
  output logic                mc_trigger,
  output logic                mc_quad,
  output logic [11:0]         mc_data_in_count,
  output logic [11:0]         mc_data_out_count,
  output logic [DIN_W-1:0]    mc_data_in,
  input  logic [63:0]         mc_readout,
  input  logic                mc_busy,
  input  logic                mc_error
);

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam logic [63:0] ALL_ONES = '1;

  state_t              state;
  op_code_t            code_q;
  logic [23:0]         addr_q;
  logic [8:0]          len_q;
  logic [MAXCMD*8-1:0] wdata_q;
  logic [PCW-1:0]      poll_cnt;
  logic                txn_start, txn_done, txn_error, args_bad;
  logic [63:0]         txn_readout;

  function automatic logic [DIN_W-1:0] frame_cmd(input logic [7:0] opc);
    frame_cmd = {opc, {(DIN_W-8){1'b0}}};
  endfunction

  // opcode + address + first nbytes of payload; everything after is zeroed
  function automatic logic [DIN_W-1:0] frame_addr(input logic [7:0] opc, input logic [23:0] addr,
                                                  input logic [8:0] nbytes,
                                                  input logic [MAXCMD*8-1:0] payload);
    logic [MAXCMD*8-1:0] keep;
    logic [DIN_W+7:0]    full;
    keep = ~({(MAXCMD*8){1'b1}} >> {nbytes, 3'b000});
    full = {opc, addr, payload & keep};
    frame_addr = full[DIN_W+7:8];
  endfunction

  always_comb begin
    args_bad = 1'b0;
    case (code_q)
      OP_READ:    args_bad = (len_q == 9'd0) || (len_q > 9'd8);
      OP_PROGRAM: args_bad = (len_q == 9'd0) || (32'(len_q) > 32'(MAXCMD - 1)) ||
                             (({2'b00, addr_q[7:0]} + {1'b0, len_q}) > 10'd256);
      OP_ERASE:   args_bad = 1'b0;
      default:    args_bad = 1'b1;
    endcase
  end

  assign mc_quad = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_INIT;
      op_ready          <= 1'b0;
      done              <= 1'b0;
      err_code          <= ERR_OK;
      rdata             <= '0;
      mc_data_in        <= '0;
      mc_data_in_count  <= '0;
      mc_data_out_count <= '0;
      txn_start         <= 1'b0;
      poll_cnt          <= '0;
    end else begin
      txn_start <= 1'b0;
      done      <= 1'b0;
      // any failed transaction aborts the whole sequence
      if (txn_done && txn_error) begin
        state    <= ST_RESP;
        done     <= 1'b1;
        err_code <= ERR_CTRL;
      end else begin
        case (state)
          ST_INIT: if (!mc_busy) begin
            state    <= ST_IDLE;
            op_ready <= 1'b1;
          end
          ST_IDLE: if (op_valid && op_ready) begin
            code_q   <= op_code_t'(op_code);
            addr_q   <= op_addr;
            len_q    <= op_len;
            wdata_q  <= op_wdata;
            op_ready <= 1'b0;
            state    <= ST_CHECK;
          end
          ST_CHECK: begin
            if (args_bad) begin
              state    <= ST_RESP;
              done     <= 1'b1;
              err_code <= ERR_ARGS;
            end else if (code_q == OP_READ) begin
              mc_data_in        <= frame_addr(CMD_READ, addr_q, 9'd0, '0);
              mc_data_in_count  <= 12'd4;
              mc_data_out_count <= {3'b000, len_q};
              txn_start         <= 1'b1;
              state             <= ST_CMD;
            end else begin
              mc_data_in        <= frame_cmd(CMD_WREN);
              mc_data_in_count  <= 12'd1;
              mc_data_out_count <= 12'd0;
              txn_start         <= 1'b1;
              state             <= ST_WREN;
            end
          end
          ST_WREN: if (txn_done) begin
            mc_data_in        <= frame_cmd(CMD_RDSR);
            mc_data_in_count  <= 12'd1;
            mc_data_out_count <= 12'd1;
            txn_start         <= 1'b1;
            state             <= ST_WEL_RD;
          end
          ST_WEL_RD: if (txn_done) begin
            if (!txn_readout[1]) begin
              state    <= ST_RESP;
              done     <= 1'b1;
              err_code <= ERR_WEL;
            end else begin
              if (code_q == OP_PROGRAM) begin
                mc_data_in       <= frame_addr(CMD_PP, addr_q, len_q, wdata_q);
                mc_data_in_count <= 12'd4 + {3'b000, len_q};
              end else begin
                mc_data_in       <= frame_addr(CMD_SE, addr_q, 9'd0, '0);
                mc_data_in_count <= 12'd4;
              end
              mc_data_out_count <= 12'd0;
              txn_start         <= 1'b1;
              state             <= ST_CMD;
            end
          end
          ST_CMD: if (txn_done) begin
            if (code_q == OP_READ) begin
              rdata    <= txn_readout & (ALL_ONES >> (7'd64 - {len_q[3:0], 3'b000}));
              state    <= ST_RESP;
              done     <= 1'b1;
              err_code <= ERR_OK;
            end else begin
              mc_data_in        <= frame_cmd(CMD_RDSR);
              mc_data_in_count  <= 12'd1;
              mc_data_out_count <= 12'd1;
              poll_cnt          <= '0;
              txn_start         <= 1'b1;
              state             <= ST_POLL;
            end
          end
          // poll_cnt counts completed polls and stops at POLL_MAX
          ST_POLL: if (txn_done) begin
            if (!txn_readout[0]) begin
              state    <= ST_RESP;
              done     <= 1'b1;
              err_code <= ERR_OK;
            end else if (poll_cnt >= PCW'(POLL_MAX - 1)) begin
              poll_cnt <= PCW'(POLL_MAX);
              state    <= ST_RESP;
              done     <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end else begin
              poll_cnt  <= poll_cnt + 1'b1;
              txn_start <= 1'b1;
            end
          end
          ST_RESP: begin
            op_ready <= 1'b1;
            state    <= ST_IDLE;
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  qspi_txn_issuer u_txn (
    .clk         (clk),
    .reset       (reset),
    .start       (txn_start),
    .mc_busy     (mc_busy),
    .mc_error    (mc_error),
    .mc_readout  (mc_readout),
    .mc_trigger  (mc_trigger),
    .txn_done    (txn_done),
    .txn_error   (txn_error),
    .txn_readout (txn_readout)
  );

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Bench for qspi_flash_sequencer: behavioural controller model plus
// scoreboards for expected transactions and expected results.
module tb_qspi_flash_sequencer;
  import qspi_flash_pkg::*;

  localparam int MAXCMD   = 256;
  localparam int POLL_MAX = 4;
  localparam int DIN_W    = (3 + MAXCMD) * 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                op_valid, op_ready;
  logic [1:0]          op_code;
  logic [23:0]         op_addr;
  logic [8:0]          op_len;
  logic [MAXCMD*8-1:0] op_wdata;
  logic                done;
  logic [2:0]          err_code;
  logic [63:0]         rdata;
  logic                mc_trigger, mc_quad;
  logic [11:0]         mc_data_in_count, mc_data_out_count;
  logic [DIN_W-1:0]    mc_data_in;
  logic [63:0]         mc_readout = '0;
  logic                mc_busy = 1'b1;
  logic                mc_error = 1'b0;

  qspi_flash_sequencer #(.MAXCMD(MAXCMD), .POLL_MAX(POLL_MAX)) dut (
    .clk               (clk),
    .reset             (reset),
    .op_valid          (op_valid),
    .op_ready          (op_ready),
    .op_code           (op_code),
    .op_addr           (op_addr),
    .op_len            (op_len),
    .op_wdata          (op_wdata),
    .done              (done),
    .err_code          (err_code),
    .rdata             (rdata),
    .mc_trigger        (mc_trigger),
    .mc_quad           (mc_quad),
    .mc_data_in_count  (mc_data_in_count),
    .mc_data_out_count (mc_data_out_count),
    .mc_data_in        (mc_data_in),
    .mc_readout        (mc_readout),
    .mc_busy           (mc_busy),
    .mc_error          (mc_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  hdr;
    logic [11:0]  in_cnt;
    logic [11:0]  out_cnt;
    bit           chk;
    logic [135:0] pl;
  } txn_t;

  typedef struct {
    logic [2:0]  err;
    bit          chk_rd;
    logic [63:0] rd;
    int          lat;
  } res_t;

  txn_t        exp_txn[$];
  res_t        exp_res[$];
  logic [63:0] resp_q[$];
  txn_t        cur;
  res_t        r;
  int          vectors = 0, miscompares = 0;
  int          trig_count = 0, done_count = 0, cyc = 0, accept_cyc = 0, busy_left = 3;
  logic [63:0] pend_rd = '0;
  logic        pend_err = 1'b0, err_on_next = 1'b0;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // controller model: busy for 3 cycles after reset and after each trigger
  always @(negedge clk) begin
    if (reset) begin
      mc_busy   = 1'b1;
      mc_error  = 1'b0;
      busy_left = 3;
      pend_rd   = '0;
      pend_err  = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        mc_busy    = 1'b0;
        mc_readout = pend_rd;
        mc_error   = pend_err;
      end
    end else if (mc_trigger) begin
      trig_count++;
      check_eq("txn_expected", exp_txn.size() != 0, 1);
      if (exp_txn.size() != 0) begin
        cur = exp_txn.pop_front();
        check_eq("txn_header", mc_data_in[DIN_W-1 -: 32], cur.hdr);
        check_eq("txn_in_count", mc_data_in_count, cur.in_cnt);
        check_eq("txn_out_count", mc_data_out_count, cur.out_cnt);
        if (cur.chk) check_eq("txn_payload", mc_data_in[DIN_W-33 -: 136], cur.pl);
      end
      pend_rd   = (resp_q.size() != 0) ? resp_q.pop_front() : 64'd0;
      pend_err  = err_on_next;
      mc_busy   = 1'b1;
      mc_error  = 1'b0;
      busy_left = 3;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      check_eq("done_expected", exp_res.size() != 0, 1);
      if (exp_res.size() != 0) begin
        r = exp_res.pop_front();
        check_eq("err_code", err_code, r.err);
        if (r.chk_rd) check_eq("rdata", rdata, r.rd);
        if (r.lat >= 0) check_eq("done_latency", cyc - accept_cyc, r.lat);
      end
    end
  end

  task automatic push_txn(input logic [31:0] hdr, input int inc, input int outc);
    txn_t t;
    t.hdr = hdr; t.in_cnt = 12'(inc); t.out_cnt = 12'(outc); t.chk = 1'b0; t.pl = '0;
    exp_txn.push_back(t);
  endtask

  task automatic push_txn_pl(input logic [31:0] hdr, input int inc, input logic [135:0] pl);
    txn_t t;
    t.hdr = hdr; t.in_cnt = 12'(inc); t.out_cnt = 12'd0; t.chk = 1'b1; t.pl = pl;
    exp_txn.push_back(t);
  endtask

  task automatic push_res(input logic [2:0] err, input bit chk_rd, input logic [63:0] rd, input int lat);
    res_t t;
    t.err = err; t.chk_rd = chk_rd; t.rd = rd; t.lat = lat;
    exp_res.push_back(t);
  endtask

  task automatic send_op(input logic [1:0] code, input logic [23:0] addr, input logic [8:0] len,
                         input logic [MAXCMD*8-1:0] wd);
    int n;
    @(negedge clk);
    op_valid = 1'b1; op_code = code; op_addr = addr; op_len = len; op_wdata = wd;
    n = 0;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("op_ready_seen", op_ready, 1);
    accept_cyc = cyc;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int base, input int ntx);
    int n;
    n = 0;
    while (exp_res.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_result_pending"}, exp_res.size(), 0);
    repeat (4) @(negedge clk);
    check_eq({tag, "_txn_count"}, trig_count - base, ntx);
    check_eq({tag, "_txn_left"}, exp_txn.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_op_ready"}, op_ready, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err_code"}, err_code, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_mc_trigger"}, mc_trigger, 0);
    check_eq({tag, "_mc_data_in"}, |mc_data_in, 0);
    check_eq({tag, "_in_count"}, mc_data_in_count, 0);
    check_eq({tag, "_out_count"}, mc_data_out_count, 0);
    check_eq({tag, "_mc_quad"}, mc_quad, 0);
  endtask

  task automatic bad_args(input logic [1:0] code, input logic [23:0] addr, input logic [8:0] len);
    int base;
    base = trig_count;
    push_res(ERR_ARGS, 1'b0, '0, 2);
    send_op(code, addr, len, '0);
    finish_op("bad_args", base, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MAXCMD*8-1:0] wd;
    int base, base_done, n;
    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_addr = '0; op_len = '0; op_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("ready_while_ctrl_busy", op_ready, 0);

    // READ 4 bytes
    base = trig_count;
    push_txn(32'h03001000, 4, 4);
    resp_q.push_back(64'hDEADBEEF);
    push_res(ERR_OK, 1'b1, 64'h00000000DEADBEEF, -1);
    send_op(2'd0, 24'h001000, 9'd4, '0);
    finish_op("read4", base, 1);

    // PROGRAM ending exactly on the page boundary, three busy polls
    base = trig_count;
    wd = '1;
    wd[MAXCMD*8-1 -: 128] = 128'h101112131415161718191A1B1C1D1E1F;
    push_txn(32'h06000000, 1, 0);
    push_txn(32'h05000000, 1, 1);
    push_txn_pl(32'h020000F0, 20, {128'h101112131415161718191A1B1C1D1E1F, 8'h00});
    repeat (4) push_txn(32'h05000000, 1, 1);
    resp_q.push_back(64'h00); resp_q.push_back(64'h02); resp_q.push_back(64'h00);
    resp_q.push_back(64'h03); resp_q.push_back(64'h03); resp_q.push_back(64'h03);
    resp_q.push_back(64'h00);
    push_res(ERR_OK, 1'b0, '0, -1);
    send_op(2'd1, 24'h0000F0, 9'd16, wd);
    finish_op("program", base, 7);

    bad_args(2'd1, 24'h0000F8, 9'd16);
    bad_args(2'd0, 24'h000000, 9'd9);
    bad_args(2'd0, 24'h000000, 9'd0);
    bad_args(2'd3, 24'h000000, 9'd1);
    bad_args(2'd1, 24'h000000, 9'd0);
    bad_args(2'd1, 24'h000000, 9'd256);

    // ERASE with write-enable latch not set
    base = trig_count;
    push_txn(32'h06000000, 1, 0);
    push_txn(32'h05000000, 1, 1);
    resp_q.push_back(64'h00); resp_q.push_back(64'h00);
    push_res(ERR_WEL, 1'b0, '0, -1);
    send_op(2'd2, 24'h010000, 9'd0, '0);
    finish_op("erase_wel", base, 2);

    // ERASE with WIP stuck: exactly POLL_MAX polls
    base = trig_count;
    push_txn(32'h06000000, 1, 0);
    push_txn(32'h05000000, 1, 1);
    push_txn(32'hD8120000, 4, 0);
    repeat (POLL_MAX) push_txn(32'h05000000, 1, 1);
    resp_q.push_back(64'h00); resp_q.push_back(64'h02); resp_q.push_back(64'h00);
    repeat (POLL_MAX) resp_q.push_back(64'h01);
    push_res(ERR_TIMEOUT, 1'b0, '0, -1);
    send_op(2'd2, 24'h120000, 9'd0, '0);
    finish_op("erase_timeout", base, 7);

    // READ 8 bytes
    base = trig_count;
    push_txn(32'h03ABCDEF, 4, 8);
    resp_q.push_back(64'h0102030405060708);
    push_res(ERR_OK, 1'b1, 64'h0102030405060708, -1);
    send_op(2'd0, 24'hABCDEF, 9'd8, '0);
    finish_op("read8", base, 1);

    // READ with controller error
    base = trig_count;
    err_on_next = 1'b1;
    push_txn(32'h03000010, 4, 2);
    resp_q.push_back(64'hFFFF);
    push_res(ERR_CTRL, 1'b0, '0, -1);
    send_op(2'd0, 24'h000010, 9'd2, '0);
    finish_op("read_ctrl_err", base, 1);
    err_on_next = 1'b0;

    // reset in the middle of status polling
    base = trig_count;
    push_txn(32'h06000000, 1, 0);
    push_txn(32'h05000000, 1, 1);
    push_txn(32'hD8200000, 4, 0);
    repeat (20) push_txn(32'h05000000, 1, 1);
    resp_q.push_back(64'h00); resp_q.push_back(64'h02); resp_q.push_back(64'h00);
    repeat (20) resp_q.push_back(64'h01);
    send_op(2'd2, 24'h200000, 9'd0, '0);
    n = 0;
    while (trig_count < base + 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("poll_reached", trig_count >= base + 4, 1);
    base_done = done_count;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    exp_txn.delete();
    resp_q.delete();
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("no_done_after_reset", done_count - base_done, 0);
    check_eq("ready_after_reset", op_ready, 1);

    base = trig_count;
    push_txn(32'h03004000, 4, 3);
    resp_q.push_back(64'hA1B2C3);
    push_res(ERR_OK, 1'b1, 64'h0000000000A1B2C3, -1);
    send_op(2'd0, 24'h004000, 9'd3, '0);
    finish_op("read_after_reset", base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
